// File: rtl/regfile_scoreboard.sv
// General-purpose register file with write bypass, hardwired r0,
// per-register pending-write scoreboard and a registered write trace.
module regfile_scoreboard #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned PEND_W = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     iss_valid_i,
    input  logic [ADDR_W-1:0]        iss_addr_i,
    output logic                     iss_ready_o,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     wr_retire_i,
    output logic                     trace_valid_o,
    output logic [ADDR_W-1:0]        trace_addr_o,
    output logic [DATA_W-1:0]        trace_data_o
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    typedef logic [PEND_W-1:0] cnt_t;

    logic [DATA_W-1:0] regs_q [NREGS];
    cnt_t              cnt_q  [NREGS];
    cnt_t              cnt_d  [NREGS];

    logic              wr_ok;
    logic              inc_ok;
    logic              dec_ok;
    logic [NREGS-1:0]  inc_v;
    logic [NREGS-1:0]  dec_v;

    logic              trace_valid_q;
    logic [ADDR_W-1:0] trace_addr_q;
    logic [DATA_W-1:0] trace_data_q;

    // r0 is never a real destination: no write, no retire, no pending state
    assign wr_ok  = wr_en_i && (wr_addr_i != '0);
    assign dec_ok = wr_ok && wr_retire_i;

    assign iss_ready_o = (iss_addr_i == '0)
                      || (cnt_q[iss_addr_i] != '1)
                      || (dec_ok && (wr_addr_i == iss_addr_i));

    assign inc_ok = iss_valid_i && iss_ready_o && (iss_addr_i != '0);

    assign inc_v = inc_ok ? (NREGS'(1) << iss_addr_i) : '0;
    assign dec_v = dec_ok ? (NREGS'(1) << wr_addr_i) : '0;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_v[r] && !dec_v[r]) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec_v[r] && !inc_v[r] && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic              byp;
        logic              clr;

        assign a   = rd_addr_i[i*ADDR_W +: ADDR_W];
        assign byp = BYPASS && wr_ok && (wr_addr_i == a);
        // a producer retiring this cycle frees the reader early
        assign clr = BYPASS && dec_v[a] && !inc_v[a]
                  && (cnt_q[a] == cnt_t'(1));

        assign rd_data_o[i*DATA_W +: DATA_W] =
            (a == '0) ? '0 : (byp ? wr_data_i : regs_q[a]);
        assign rd_busy_o[i] = (cnt_q[a] != '0) && !clr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            trace_valid_q <= 1'b0;
            trace_addr_q  <= '0;
            trace_data_q  <= '0;
        end else begin
            if (wr_ok) begin
                regs_q[wr_addr_i] <= wr_data_i;
                trace_addr_q      <= wr_addr_i;
                trace_data_q      <= wr_data_i;
            end
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            trace_valid_q <= wr_ok;
        end
    end

    assign trace_valid_o = trace_valid_q;
    assign trace_addr_o  = trace_addr_q;
    assign trace_data_o  = trace_data_q;

`ifndef SYNTHESIS
    // retiring a register with no outstanding producer is a protocol error
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(dec_ok && (cnt_q[wr_addr_i] == '0)));
        end
    end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed reset/r0/bypass sequences,
// a vector table for scoreboard corners, and a random 3-port run.
module tb_regfile_scoreboard;

    logic clk;
    logic reset;

    int checks;
    int errors;

    // shared stimulus for the 32-bit BYPASS=1 and BYPASS=0 instances
    logic [9:0]  rd_addr;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_retire;

    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic        a_iss_ready;
    logic        a_tv;
    logic [4:0]  a_ta;
    logic [31:0] a_td;

    logic [63:0] b_rd_data;
    logic [1:0]  b_rd_busy;
    logic        b_iss_ready;
    logic        b_tv;
    logic [4:0]  b_ta;
    logic [31:0] b_td;

    logic [14:0]  c_rd_addr;
    logic [191:0] c_rd_data;
    logic [2:0]   c_rd_busy;
    logic         c_iv;
    logic [4:0]   c_ia;
    logic         c_rdy;
    logic         c_we;
    logic [4:0]   c_wa;
    logic [63:0]  c_wd;
    logic         c_rt;
    logic         c_tv;
    logic [4:0]   c_ta;
    logic [63:0]  c_td;

    regfile_scoreboard u_a (
        .clk(clk), .reset(reset),
        .rd_addr_i(rd_addr), .rd_data_o(a_rd_data),
        .rd_busy_o(a_rd_busy),
        .iss_valid_i(iss_valid), .iss_addr_i(iss_addr),
        .iss_ready_o(a_iss_ready),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_retire_i(wr_retire),
        .trace_valid_o(a_tv), .trace_addr_o(a_ta),
        .trace_data_o(a_td)
    );

    regfile_scoreboard #(.BYPASS(1'b0)) u_b (
        .clk(clk), .reset(reset),
        .rd_addr_i(rd_addr), .rd_data_o(b_rd_data),
        .rd_busy_o(b_rd_busy),
        .iss_valid_i(iss_valid), .iss_addr_i(iss_addr),
        .iss_ready_o(b_iss_ready),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_retire_i(wr_retire),
        .trace_valid_o(b_tv), .trace_addr_o(b_ta),
        .trace_data_o(b_td)
    );

    regfile_scoreboard #(.NUM_RD(3), .DATA_W(64)) u_c (
        .clk(clk), .reset(reset),
        .rd_addr_i(c_rd_addr), .rd_data_o(c_rd_data),
        .rd_busy_o(c_rd_busy),
        .iss_valid_i(c_iv), .iss_addr_i(c_ia),
        .iss_ready_o(c_rdy),
        .wr_en_i(c_we), .wr_addr_i(c_wa),
        .wr_data_i(c_wd), .wr_retire_i(c_rt),
        .trace_valid_o(c_tv), .trace_addr_o(c_ta),
        .trace_data_o(c_td)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        iv;
        logic [4:0]  ia;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        rt;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        b0;
        logic        b1;
        logic        rdy;
        logic        tv;
        logic [4:0]  ta;
        logic [31:0] td;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(
        input logic iv, input logic [4:0] ia,
        input logic we, input logic [4:0] wa,
        input logic [31:0] wd, input logic rt,
        input logic [4:0] ra0, input logic [4:0] ra1,
        input logic [31:0] d0, input logic [31:0] d1,
        input logic b0, input logic b1, input logic rdy,
        input logic tv, input logic [4:0] ta,
        input logic [31:0] td);
        vec_t v;
        v.iv = iv; v.ia = ia; v.we = we; v.wa = wa;
        v.wd = wd; v.rt = rt; v.ra0 = ra0; v.ra1 = ra1;
        v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1;
        v.rdy = rdy; v.tv = tv; v.ta = ta; v.td = td;
        return v;
    endfunction

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_addr = '0;
        wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; wr_retire = 1'b0;
    endtask

    int          cnt_m [32];
    logic [63:0] reg_m [32];
    logic        tv_m;
    logic [4:0]  ta_m;
    logic [63:0] td_m;
    logic        stall;
    logic        dec_m;
    logic        inc_m;
    logic        rdy_m;
    logic [4:0]  pa;
    logic        busy_m;
    logic [63:0] data_m;

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        idle();
        rd_addr = '0;
        c_rd_addr = '0;
        c_iv = 1'b0; c_ia = '0; c_we = 1'b0;
        c_wa = '0; c_wd = '0; c_rt = 1'b0;

        // reset, then async reset mid-cycle
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        rd_addr = {5'd0, 5'd5};
        #1;
        chk("rst_busy", 64'(a_rd_busy), 64'd0);
        chk("rst_tv", 64'(a_tv), 64'd0);
        chk("rst_ready", 64'(a_iss_ready), 64'd1);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234;
        iss_valid = 1'b1; iss_addr = 5'd5;
        tick();
        idle();
        #1;
        chk("r5_written", 64'(a_rd_data[31:0]), 64'h1234);
        chk("r5_busy", 64'(a_rd_busy[0]), 64'd1);
        chk("r5_trace", 64'({a_tv, a_ta}), 64'({1'b1, 5'd5}));
        #2 reset = 1'b1;
        #1;
        chk("async_rd", 64'(a_rd_data[31:0]), 64'd0);
        chk("async_busy", 64'(a_rd_busy), 64'd0);
        chk("async_tv", 64'(a_tv), 64'd0);
        chk("async_ta", 64'(a_ta), 64'd0);
        chk("async_td", 64'(a_td), 64'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        tick();

        // r0 write and issue are dropped
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF;
        wr_retire = 1'b1;
        iss_valid = 1'b1; iss_addr = 5'd0;
        rd_addr = {5'd0, 5'd0};
        @(negedge clk);
        chk("r0_rd", 64'(a_rd_data[31:0]), 64'd0);
        chk("r0_ready", 64'(a_iss_ready), 64'd1);
        chk("r0_busy", 64'(a_rd_busy[0]), 64'd0);
        tick();
        chk("r0_notrace", 64'(a_tv), 64'd0);
        chk("r0_busy_after", 64'(a_rd_busy[0]), 64'd0);
        chk("r0_rd_after", 64'(a_rd_data[31:0]), 64'd0);
        idle();

        // bypass vs no bypass
        rd_addr = {5'd0, 5'd7};
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        @(negedge clk);
        chk("byp1_rd", 64'(a_rd_data[31:0]), 64'hA5A5A5A5);
        chk("byp0_rd_old", 64'(b_rd_data[31:0]), 64'd0);
        tick();
        idle();
        #1;
        chk("byp0_rd_new", 64'(b_rd_data[31:0]), 64'hA5A5A5A5);
        chk("byp_trace", 64'({a_tv, a_ta, a_td}),
            64'({1'b1, 5'd7, 32'hA5A5A5A5}));

        // scoreboard saturation, retire-to-zero
        tbl[0]  = mk(1,3,0,0,0,0, 3,3, 0,0, 0,0,1, 0,7,32'hA5A5A5A5);
        tbl[1]  = mk(1,3,0,0,0,0, 3,3, 0,0, 1,1,1, 0,7,32'hA5A5A5A5);
        tbl[2]  = mk(1,3,0,0,0,0, 3,3, 0,0, 1,1,1, 0,7,32'hA5A5A5A5);
        tbl[3]  = mk(0,3,0,0,0,0, 3,3, 0,0, 1,1,0, 0,7,32'hA5A5A5A5);
        tbl[4]  = mk(0,3,1,3,'h33,1, 3,3, 'h33,'h33, 1,1,1, 1,3,'h33);
        tbl[5]  = mk(1,3,0,0,0,0, 3,3, 'h33,'h33, 1,1,1, 0,3,'h33);
        tbl[6]  = mk(1,3,1,3,'h44,1, 3,3, 'h44,'h44, 1,1,1, 1,3,'h44);
        tbl[7]  = mk(0,3,0,0,0,0, 3,3, 'h44,'h44, 1,1,0, 0,3,'h44);
        tbl[8]  = mk(0,3,1,3,'h50,1, 3,3, 'h50,'h50, 1,1,1, 1,3,'h50);
        tbl[9]  = mk(0,3,1,3,'h51,1, 3,3, 'h51,'h51, 1,1,1, 1,3,'h51);
        tbl[10] = mk(0,3,1,3,'h52,1, 3,3, 'h52,'h52, 0,0,1, 1,3,'h52);
        tbl[11] = mk(0,3,0,0,0,0, 3,3, 'h52,'h52, 0,0,1, 0,3,'h52);
        tbl[12] = mk(1,9,0,0,0,0, 9,0, 0,0, 0,0,1, 0,3,'h52);
        tbl[13] = mk(0,9,1,9,'h55,1, 9,0, 'h55,0, 0,0,1, 1,9,'h55);
        tbl[14] = mk(0,9,0,0,0,0, 9,0, 'h55,0, 0,0,1, 0,9,'h55);

        for (int k = 0; k < 15; k++) begin
            iss_valid = tbl[k].iv; iss_addr = tbl[k].ia;
            wr_en = tbl[k].we; wr_addr = tbl[k].wa;
            wr_data = tbl[k].wd; wr_retire = tbl[k].rt;
            rd_addr = {tbl[k].ra1, tbl[k].ra0};
            @(negedge clk);
            chk($sformatf("v%0d_d0", k), 64'(a_rd_data[31:0]), 64'(tbl[k].d0));
            chk($sformatf("v%0d_d1", k), 64'(a_rd_data[63:32]), 64'(tbl[k].d1));
            chk($sformatf("v%0d_b0", k), 64'(a_rd_busy[0]), 64'(tbl[k].b0));
            chk($sformatf("v%0d_b1", k), 64'(a_rd_busy[1]), 64'(tbl[k].b1));
            chk($sformatf("v%0d_rdy", k), 64'(a_iss_ready), 64'(tbl[k].rdy));
            if (k == 10) begin
                chk("nobyp_busy_retire", 64'(b_rd_busy[0]), 64'd1);
            end
            tick();
            chk($sformatf("v%0d_tv", k), 64'(a_tv), 64'(tbl[k].tv));
            chk($sformatf("v%0d_ta", k), 64'(a_ta), 64'(tbl[k].ta));
            chk($sformatf("v%0d_td", k), 64'(a_td), 64'(tbl[k].td));
        end
        idle();

        // random 3-port 64-bit run against a reference model
        for (int r = 0; r < 32; r++) begin
            cnt_m[r] = 0;
            reg_m[r] = '0;
        end
        tv_m = 1'b0; ta_m = '0; td_m = '0;
        stall = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (!stall) begin
                c_iv = ($urandom_range(0, 3) != 0);
                c_ia = 5'($urandom_range(0, 7));
            end
            c_we = ($urandom_range(0, 3) != 0);
            c_wa = 5'($urandom_range(0, 7));
            c_wd = {$urandom, $urandom};
            c_rt = c_we && (cnt_m[c_wa] > 0) && ($urandom_range(0, 1) == 1);
            for (int i = 0; i < 3; i++) begin
                c_rd_addr[i*5 +: 5] = 5'($urandom_range(0, 7));
            end
            dec_m = c_rt && (c_wa != 0);
            rdy_m = (c_ia == 0) || (cnt_m[c_ia] < 3)
                 || (dec_m && (c_wa == c_ia));
            inc_m = c_iv && rdy_m && (c_ia != 0);
            @(negedge clk);
            chk($sformatf("rnd%0d_rdy", n), 64'(c_rdy), 64'(rdy_m));
            for (int i = 0; i < 3; i++) begin
                pa = c_rd_addr[i*5 +: 5];
                if (pa == 0) data_m = '0;
                else if (c_we && (c_wa == pa)) data_m = c_wd;
                else data_m = reg_m[pa];
                busy_m = (pa != 0) && (cnt_m[pa] != 0)
                      && !(dec_m && (c_wa == pa) && (cnt_m[pa] == 1)
                           && !(inc_m && (c_ia == pa)));
                chk($sformatf("rnd%0d_d%0d", n, i),
                    c_rd_data[i*64 +: 64], data_m);
                chk($sformatf("rnd%0d_b%0d", n, i),
                    64'(c_rd_busy[i]), 64'(busy_m));
            end
            stall = c_iv && !rdy_m;
            tick();
            if (inc_m) cnt_m[c_ia] = cnt_m[c_ia] + 1;
            if (dec_m) cnt_m[c_wa] = cnt_m[c_wa] - 1;
            tv_m = c_we && (c_wa != 0);
            if (tv_m) begin
                reg_m[c_wa] = c_wd;
                ta_m = c_wa;
                td_m = c_wd;
            end
            chk($sformatf("rnd%0d_tv", n), 64'(c_tv), 64'(tv_m));
            chk($sformatf("rnd%0d_ta", n), 64'(c_ta), 64'(ta_m));
            chk($sformatf("rnd%0d_td", n), c_td, td_m);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
